bus_select_reg: RTL and testbench
=================================

# bus_select_reg

Registered, parametrised datapath bus selector for the processor core. It drives `BusWires` from one of `NREG` general registers, the `DIN` input or the `G` accumulator. The output is captured on the clock edge, so downstream register loads see a glitch-free bus. It holds the last legal value when no source is enabled, and detects and counts multi-driver conflicts instead of silently overwriting.

## Interface
Parameters:
- `WIDTH`, 16, data width of every source and of `BusWires`
- `NREG`, 8, number of general registers (R0..R(NREG-1)), minimum 2
- `CNT_W`, 8, width of the saturating conflict counter

Ports:
- `Clock`  in  1  single clock; all state updates on its rising edge
- `Resetn`  in  1  asynchronous, active-low reset
- `Rout`  in  NREG  register output enables; `Rout[NREG-1-i]` enables Ri (MSB = R0)
- `Gout`  in  1  enable G onto bus
- `DINout`  in  1  enable DIN onto bus
- `r_data`  in  NREG*WIDTH  flattened register file; Ri occupies bits `[i*WIDTH +: WIDTH]`
- `g_data`  in  WIDTH  G register value
- `din_data`  in  WIDTH  DIN value
- `clear_err`  in  1  clears `conflict` and `conflict_cnt`
- `BusWires`  out  WIDTH  registered bus value
- `bus_valid`  out  1  high for the cycle after a legal single-source capture
- `bus_src`  out  SRC_W  encoded source of the current `BusWires` value
- `conflict`  out  1  sticky multi-driver flag
- `conflict_cnt`  out  CNT_W  saturating count of conflict cycles

## Operation
- Enable vector E = {Gout, DINout, Rout}, NREG+2 bits. n = popcount(E), evaluated each cycle.
- Source encoding in `bus_src`:
  - 0..NREG-1 = Ri
  - NREG = DIN
  - NREG+1 = G
  - `SRC_W = $clog2(NREG+2)`
- n == 1: capture the selected data into `BusWires`, load `bus_src`, set `bus_valid` = 1.
- n == 0: `BusWires` and `bus_src` hold, `bus_valid` = 0.
- n >= 2 (conflict): `conflict` sets, `conflict_cnt` increments and saturates at 2^CNT_W-1, `bus_valid` = 0. `BusWires` and `bus_src` behaviour depends on the configuration below.
- `clear_err` zeroes `conflict` and `conflict_cnt`. If a conflict occurs in the same cycle, set wins: `conflict` = 1 and `conflict_cnt` = 1.
- No combinational path from any input to any output.

## Timing
- Latency 1 cycle: enables and data sampled at rising edge k appear on `BusWires`/`bus_src`/`bus_valid` after edge k.
- `bus_valid` is a one-cycle-per-capture pulse. Back-to-back legal selects keep it high continuously.
- Reset (`Resetn` low, asynchronous, any time including mid-transfer):
  - `BusWires` = 0, `bus_src` = 0, `bus_valid` = 0, `conflict` = 0, `conflict_cnt` = 0.
  - The first capture occurs on the first rising edge with `Resetn` high.
- Data inputs change freely between edges. Only values at the edge matter.

## Configuration
- Macro `BUS_SELECT_PRIORITY_EN`.
- Defined: on conflict, fixed priority resolves the bus and that source is captured; `bus_valid` stays 0 and the conflict is still flagged and counted.
  - Priority order: G > DIN > R0 > R1 > ... > R(NREG-1).
- Undefined: on conflict, `BusWires` and `bus_src` hold their previous values.

## Structure
- Shared package `bus_pkg`:
  - `SRC_W` computation function
  - source-code constants: `SRC_DIN` = NREG, `SRC_G` = NREG+1
  - typedef for the source code
- One sub-module `bus_onehot_enc`: combinational popcount-class output (zero / one / many) plus priority encode of E into a source code. It is reused by the control unit for register-write enables.

## Test plan
- After reset, all outputs 0; idle cycles with n=0 keep `BusWires` = 0 and `bus_valid` = 0.
- `r_data` R3=16'h00A5, `Rout`=8'b0001_0000 for one cycle -> next cycle `BusWires`=16'h00A5, `bus_src`=3, `bus_valid`=1. Then `Rout`=0 -> value held, `bus_valid`=0.
- `DINout`=1 with `din_data`=16'h1234, then `Gout`=1 with `g_data`=16'hBEEF on consecutive edges -> `BusWires` 16'h1234 then 16'hBEEF, `bus_src` 8 then 9, `bus_valid` high for both cycles.
- `Gout`=1 and `Rout`=8'b1000_0000 together -> `conflict`=1, `conflict_cnt`=1.
  - Without macro: `BusWires` unchanged.
  - With macro: `BusWires`=`g_data`, `bus_src`=9.
- 300 consecutive conflict cycles -> `conflict_cnt` stops at 255. Then `clear_err` plus a simultaneous conflict -> `conflict`=1, `conflict_cnt`=1.
- `Resetn` asserted between edges while `bus_valid`=1 -> all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared definitions for the processor-core bus selector and its enable encoder.
// Holds the source-code width helper, the DIN/G source code constants and the
// enable-count class used to tell idle, legal and conflicting cycles apart.
package bus_pkg;

  // Default register count; per-instance widths come from the helpers below
  localparam int DEF_NREG = 8;

  // Width of a source code able to name R0..R(nreg-1), DIN and G
  function automatic int bus_src_w(input int nreg);
    return $clog2(nreg + 2);
  endfunction

  // Source code of DIN / G for a given register count
  function automatic int src_din(input int nreg);
    return nreg;
  endfunction

  function automatic int src_g(input int nreg);
    return nreg + 1;
  endfunction

  localparam int SRC_DIN = DEF_NREG;
  localparam int SRC_G   = DEF_NREG + 1;
  localparam int SRC_W   = $clog2(DEF_NREG + 2);

  // Source code for the default configuration
  typedef logic [SRC_W-1:0] src_t;

  // Number of enables asserted in a cycle: none, exactly one, or several
  typedef enum logic [1:0] {
    CLS_ZERO = 2'd0,
    CLS_ONE  = 2'd1,
    CLS_MANY = 2'd2
  } en_cls_t;

endpackage

// File: rtl/bus_onehot_enc.sv
// Enable-vector classifier: reports zero / one / many asserted bits and the
// index of the highest asserted bit (MSB has highest priority). Purely
// combinational; also used by the control unit for register-write enables.
module bus_onehot_enc
  import bus_pkg::*;
#(
  parameter int N     = 10,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     en,
  output en_cls_t          cls,
  output logic [IDX_W-1:0] idx
);

  // Popcount class: clearing the lowest set bit leaves zero only for one-hot
  always_comb begin
    cls = CLS_MANY;
    if (en == '0) begin
      cls = CLS_ZERO;
    end else if ((en & (en - N'(1))) == '0) begin
      cls = CLS_ONE;
    end
  end

  // Priority encode: later (higher) bits overwrite, so the MSB wins
  always_comb begin
    idx = '0;
    for (int j = 0; j < N; j++) begin
      if (en[j]) begin
        idx = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/bus_select_reg.sv
// Registered bus selector: drives BusWires from one of NREG registers, DIN or G.
// Latency 1 cycle; holds the last legal value when idle; flags and counts conflicts.
// Optional macro BUS_SELECT_PRIORITY_EN: resolve conflicts by G > DIN > R0 > ... priority.
module bus_select_reg
  import bus_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int NREG  = 8,
  parameter int CNT_W = 8,
  localparam int SRC_W = bus_src_w(NREG)
) (
  input  logic                  Clock,
  input  logic                  Resetn,
  input  logic [NREG-1:0]       Rout,
  input  logic                  Gout,
  input  logic                  DINout,
  input  logic [NREG*WIDTH-1:0] r_data,
  input  logic [WIDTH-1:0]      g_data,
  input  logic [WIDTH-1:0]      din_data,
  input  logic                  clear_err,
  output logic [WIDTH-1:0]      BusWires,
  output logic                  bus_valid,
  output logic [SRC_W-1:0]      bus_src,
  output logic                  conflict,
  output logic [CNT_W-1:0]      conflict_cnt
);

  localparam int NE       = NREG + 2;
  localparam int CODE_DIN = src_din(NREG);
  localparam int CODE_G   = src_g(NREG);

  // E = {G, DIN, Rout}; Rout MSB is R0, so bit order already matches priority
  logic [NE-1:0]    en_vec;
  en_cls_t          en_cls;
  logic [SRC_W-1:0] en_idx;
  logic [SRC_W-1:0] sel_code;
  logic [WIDTH-1:0] sel_data;
  logic             take;
  logic             is_conflict;

  assign en_vec      = {Gout, DINout, Rout};
  assign is_conflict = (en_cls == CLS_MANY);

  bus_onehot_enc #(
    .N     (NE),
    .IDX_W (SRC_W)
  ) u_enc (
    .en  (en_vec),
    .cls (en_cls),
    .idx (en_idx)
  );

  // Convert bit position in E to source code: Rout bit j names R(NREG-1-j)
  always_comb begin
    sel_code = en_idx;
    if (int'(en_idx) < NREG) begin
      sel_code = SRC_W'(NREG - 1 - int'(en_idx));
    end
  end

  // Data mux keyed by source code
  always_comb begin
    sel_data = '0;
    if (sel_code == SRC_W'(CODE_G)) begin
      sel_data = g_data;
    end else if (sel_code == SRC_W'(CODE_DIN)) begin
      sel_data = din_data;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (sel_code == SRC_W'(i)) begin
          sel_data = r_data[i*WIDTH +: WIDTH];
        end
      end
    end
  end

`ifdef BUS_SELECT_PRIORITY_EN
  // Conflicts still drive the bus, using the highest-priority requester
  assign take = (en_cls == CLS_ONE) || is_conflict;
`else
  // Conflicts leave the bus untouched
  assign take = (en_cls == CLS_ONE);
`endif

  // Bus capture: data and source update together, valid marks legal captures only
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      BusWires  <= '0;
      bus_src   <= '0;
      bus_valid <= 1'b0;
    end else begin
      bus_valid <= (en_cls == CLS_ONE);
      if (take) begin
        BusWires <= sel_data;
        bus_src  <= sel_code;
      end
    end
  end

  // Conflict flag and saturating counter; a same-cycle conflict beats clear
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      conflict     <= 1'b0;
      conflict_cnt <= '0;
    end else if (clear_err) begin
      conflict     <= is_conflict;
      conflict_cnt <= is_conflict ? CNT_W'(1) : '0;
    end else if (is_conflict) begin
      conflict <= 1'b1;
      if (conflict_cnt != {CNT_W{1'b1}}) begin
        conflict_cnt <= conflict_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_bus_select_reg.sv
// Self-checking bench for bus_select_reg: directed scenarios plus randomized
// enables checked against a source-counting reference model.
module tb_bus_select_reg;

  localparam int WIDTH = 16;
  localparam int NREG  = 8;
  localparam int CNT_W = 8;
  localparam int SRC_W = $clog2(NREG + 2);
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic                  Clock = 1'b0;
  logic                  Resetn;
  logic [NREG-1:0]       Rout;
  logic                  Gout;
  logic                  DINout;
  logic [NREG*WIDTH-1:0] r_data;
  logic [WIDTH-1:0]      g_data;
  logic [WIDTH-1:0]      din_data;
  logic                  clear_err;
  logic [WIDTH-1:0]      BusWires;
  logic                  bus_valid;
  logic [SRC_W-1:0]      bus_src;
  logic                  conflict;
  logic [CNT_W-1:0]      conflict_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [WIDTH-1:0] m_bus;
  int               m_src;
  logic             m_valid;
  logic             m_conf;
  int               m_cnt;

  bus_select_reg #(.WIDTH(WIDTH), .NREG(NREG), .CNT_W(CNT_W)) dut (
    .Clock        (Clock),
    .Resetn       (Resetn),
    .Rout         (Rout),
    .Gout         (Gout),
    .DINout       (DINout),
    .r_data       (r_data),
    .g_data       (g_data),
    .din_data     (din_data),
    .clear_err    (clear_err),
    .BusWires     (BusWires),
    .bus_valid    (bus_valid),
    .bus_src      (bus_src),
    .conflict     (conflict),
    .conflict_cnt (conflict_cnt)
  );

  always #5 Clock = ~Clock;

  task automatic model_reset();
    m_bus = '0; m_src = 0; m_valid = 1'b0; m_conf = 1'b0; m_cnt = 0;
  endtask

  // Count requesters, pick winner by G > DIN > R0 > R1 ..., apply rules
  task automatic model_edge();
    int n;
    int first_r;
    int s;
    logic [WIDTH-1:0] d;
    n = 0; first_r = -1; s = 0; d = '0;
    for (int i = 0; i < NREG; i++) begin
      if (Rout[NREG-1-i]) begin
        n++;
        if (first_r < 0) first_r = i;
      end
    end
    if (DINout) n++;
    if (Gout) n++;
    if (Gout) begin s = NREG + 1; d = g_data; end
    else if (DINout) begin s = NREG; d = din_data; end
    else if (first_r >= 0) begin s = first_r; d = r_data[first_r*WIDTH +: WIDTH]; end
    m_valid = (n == 1);
    if (n == 1) begin m_bus = d; m_src = s; end
`ifdef BUS_SELECT_PRIORITY_EN
    if (n >= 2) begin m_bus = d; m_src = s; end
`endif
    if (clear_err) begin m_conf = 1'b0; m_cnt = 0; end
    if (n >= 2) begin
      m_conf = 1'b1;
      if (m_cnt < CMAX) m_cnt++;
    end
  endtask

  // Advance one clock edge, keeping the model in step; sample 1ns after the edge
  task automatic tick();
    model_edge();
    @(posedge Clock);
    #1;
  endtask

  task automatic idle_inputs();
    Rout = '0; Gout = 1'b0; DINout = 1'b0; clear_err = 1'b0;
  endtask

  task automatic test_reset();
    Resetn = 1'b0;
    idle_inputs();
    r_data = '0; g_data = '0; din_data = '0;
    model_reset();
    repeat (3) @(posedge Clock);
    #1;
    n_checks++; if (BusWires !== 16'h0) begin n_fail++; $display("FAIL reset_bus: got %h want 0000", BusWires); end
    n_checks++; if (bus_src !== '0) begin n_fail++; $display("FAIL reset_src: got %0d want 0", bus_src); end
    n_checks++; if (bus_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", bus_valid); end
    n_checks++; if (conflict !== 1'b0 || conflict_cnt !== '0) begin n_fail++; $display("FAIL reset_conflict: got %b/%0d want 0/0", conflict, conflict_cnt); end
    Resetn = 1'b1;
    r_data = {NREG*WIDTH/32{32'hDEAD_BEEF}};
    g_data = 16'h5555; din_data = 16'hAAAA;
    repeat (3) tick();
    n_checks++; if (BusWires !== 16'h0 || bus_valid !== 1'b0) begin n_fail++; $display("FAIL idle_hold: got bus %h valid %b want 0000/0", BusWires, bus_valid); end
  endtask

  task automatic test_single_reg();
    r_data[3*WIDTH +: WIDTH] = 16'h00A5;
    Rout = 8'b0001_0000;
    tick();
    n_checks++; if (BusWires !== 16'h00A5) begin n_fail++; $display("FAIL r3_bus: got %h want 00a5", BusWires); end
    n_checks++; if (bus_src !== SRC_W'(3)) begin n_fail++; $display("FAIL r3_src: got %0d want 3", bus_src); end
    n_checks++; if (bus_valid !== 1'b1) begin n_fail++; $display("FAIL r3_valid: got %b want 1", bus_valid); end
    Rout = '0;
    r_data[3*WIDTH +: WIDTH] = 16'h1111;
    tick();
    n_checks++; if (BusWires !== 16'h00A5 || bus_valid !== 1'b0) begin n_fail++; $display("FAIL r3_hold: got bus %h valid %b want 00a5/0", BusWires, bus_valid); end
  endtask

  task automatic test_back_to_back();
    DINout = 1'b1; din_data = 16'h1234;
    tick();
    n_checks++; if (BusWires !== 16'h1234 || bus_src !== SRC_W'(8) || bus_valid !== 1'b1) begin n_fail++; $display("FAIL din_capture: got %h/%0d/%b want 1234/8/1", BusWires, bus_src, bus_valid); end
    DINout = 1'b0; Gout = 1'b1; g_data = 16'hBEEF;
    tick();
    n_checks++; if (BusWires !== 16'hBEEF || bus_src !== SRC_W'(9) || bus_valid !== 1'b1) begin n_fail++; $display("FAIL g_capture: got %h/%0d/%b want beef/9/1", BusWires, bus_src, bus_valid); end
    Gout = 1'b0;
    tick();
    n_checks++; if (bus_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_valid_drop: got %b want 0", bus_valid); end
  endtask

  task automatic test_conflict();
    logic [WIDTH-1:0] prev_bus;
    int prev_src;
    prev_bus = m_bus; prev_src = m_src;
    Gout = 1'b1; Rout = 8'b1000_0000; g_data = 16'h7777;
    r_data[0 +: WIDTH] = 16'h0F0F;
    tick();
    idle_inputs();
    n_checks++; if (conflict !== 1'b1 || conflict_cnt !== 8'd1) begin n_fail++; $display("FAIL conflict_flag: got %b/%0d want 1/1", conflict, conflict_cnt); end
    n_checks++; if (bus_valid !== 1'b0) begin n_fail++; $display("FAIL conflict_valid: got %b want 0", bus_valid); end
`ifdef BUS_SELECT_PRIORITY_EN
    n_checks++; if (BusWires !== 16'h7777 || bus_src !== SRC_W'(9)) begin n_fail++; $display("FAIL conflict_prio: got %h/%0d want 7777/9", BusWires, bus_src); end
`else
    n_checks++; if (BusWires !== prev_bus || int'(bus_src) != prev_src) begin n_fail++; $display("FAIL conflict_hold: got %h/%0d want %h/%0d", BusWires, bus_src, prev_bus, prev_src); end
`endif
  endtask

  task automatic test_saturation();
    Gout = 1'b1; DINout = 1'b1;
    repeat (300) tick();
    n_checks++; if (conflict_cnt !== 8'd255 || conflict !== 1'b1) begin n_fail++; $display("FAIL cnt_saturate: got %0d/%b want 255/1", conflict_cnt, conflict); end
    clear_err = 1'b1;
    tick();
    n_checks++; if (conflict !== 1'b1 || conflict_cnt !== 8'd1) begin n_fail++; $display("FAIL clear_vs_set: got %b/%0d want 1/1", conflict, conflict_cnt); end
    Gout = 1'b0; DINout = 1'b0;
    tick();
    n_checks++; if (conflict !== 1'b0 || conflict_cnt !== 8'd0) begin n_fail++; $display("FAIL clear_only: got %b/%0d want 0/0", conflict, conflict_cnt); end
    idle_inputs();
  endtask

  task automatic test_async_reset();
    Rout = 8'b0000_0001; r_data[7*WIDTH +: WIDTH] = 16'hC3C3;
    Gout = 1'b1; DINout = 1'b1;
    tick();
    Gout = 1'b0; DINout = 1'b0;
    tick();
    n_checks++; if (bus_valid !== 1'b1 || BusWires !== 16'hC3C3) begin n_fail++; $display("FAIL pre_reset_capture: got %b/%h want 1/c3c3", bus_valid, BusWires); end
    #2;
    Resetn = 1'b0;
    #1;
    n_checks++; if (BusWires !== 16'h0 || bus_src !== '0 || bus_valid !== 1'b0) begin n_fail++; $display("FAIL async_reset_bus: got %h/%0d/%b want 0000/0/0", BusWires, bus_src, bus_valid); end
    n_checks++; if (conflict !== 1'b0 || conflict_cnt !== '0) begin n_fail++; $display("FAIL async_reset_err: got %b/%0d want 0/0", conflict, conflict_cnt); end
    model_reset();
    idle_inputs();
    @(posedge Clock);
    #1;
    Resetn = 1'b1;
  endtask

  task automatic test_random();
    int mode;
    for (int c = 0; c < 400; c++) begin
      idle_inputs();
      r_data = {$urandom, $urandom, $urandom, $urandom};
      g_data = WIDTH'($urandom); din_data = WIDTH'($urandom);
      mode = $urandom_range(0, 4);
      case (mode)
        0: ;
        1: Rout[$urandom_range(0, NREG-1)] = 1'b1;
        2: Gout = 1'b1;
        3: DINout = 1'b1;
        default: begin Rout = NREG'($urandom); Gout = 1'($urandom); DINout = 1'($urandom); end
      endcase
      clear_err = ($urandom_range(0, 15) == 0);
      tick();
      n_checks++;
      if (BusWires !== m_bus || int'(bus_src) != m_src || bus_valid !== m_valid || conflict !== m_conf || int'(conflict_cnt) != m_cnt) begin
        n_fail++;
        $display("FAIL random_%0d: got %h/%0d/%b/%b/%0d want %h/%0d/%b/%b/%0d", c, BusWires, bus_src, bus_valid, conflict, conflict_cnt, m_bus, m_src, m_valid, m_conf, m_cnt);
      end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_single_reg();
    test_back_to_back();
    test_conflict();
    test_saturation();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
